// File: rtl/usart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one USART tx channel among NUM_REQ byte streams.
// Optional lock-break timeout is built only when USART_ARB_TIMEOUT_EN is defined.
module usart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          comm_clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          timeout_pulse
);
    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("usart_tx_arbiter: parameter out of range");
    end

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  state;
    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        owner;
    logic [PTR_W-1:0]        pick;
    logic [PTR_W-1:0]        cand;
    logic [PTR_W-1:0]        next_ptr;
    logic                    pick_found;
    logic                    xfer;
    logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // First requesting index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        pick       = '0;
        cand       = '0;
        pick_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    // Unbuffered passthrough from the lock owner.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (state == LOCKED) begin
            tx_valid         = req_valid[owner];
            tx_data          = data_arr[owner];
            req_ready[owner] = tx_ready;
        end
    end

    assign xfer     = (state == LOCKED) && tx_valid && tx_ready;
    assign next_ptr = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
    assign busy     = (state == LOCKED);

`ifdef USART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] stall_cnt;
`else
    assign timeout_pulse = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge comm_clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            owner  <= '0;
`ifdef USART_ARB_TIMEOUT_EN
            stall_cnt     <= '0;
            timeout_pulse <= 1'b0;
`endif
        end else begin
`ifdef USART_ARB_TIMEOUT_EN
            timeout_pulse <= 1'b0;
`endif
            if (state == IDLE) begin
                if (pick_found) begin
                    state <= LOCKED;
                    owner <= pick;
                    grant <= NUM_REQ'(1) << pick;
`ifdef USART_ARB_TIMEOUT_EN
                    stall_cnt <= '0;
`endif
                end
            end else begin
                if (xfer && req_last[owner]) begin
                    state  <= IDLE;
                    grant  <= '0;
                    rr_ptr <= next_ptr;
                end
`ifdef USART_ARB_TIMEOUT_EN
                // A transfer always wins over an expiring stall count.
                if (xfer) begin
                    stall_cnt <= '0;
                end else if (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state         <= IDLE;
                    grant         <= '0;
                    rr_ptr        <= next_ptr;
                    stall_cnt     <= '0;
                    timeout_pulse <= 1'b1;
                end else begin
                    stall_cnt <= stall_cnt + CNT_W'(1);
                end
`endif
            end
        end
    end

endmodule
